// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares the core's single-ported memory bus between
// instruction fetch and the Memory stage. One outstanding transaction at a
// time; a starvation guard lets fetch win once it has lost STARVE_LIMIT
// consecutive arbitrations to data accesses.
// Optional feature macro: MEMORY_ARBITER_TIMEOUT_EN adds the busTimeout output
// and a WAIT watchdog that gives up after TIMEOUT_CYCLES without a response.
//
// state | meaning
// IDLE  | arbitrate between data and fetch, latch the winner's bus fields
// ISSUE | memRequest high, bus fields held stable until memGrant
// WAIT  | transaction accepted, awaiting memResponseValid (or timeout)
module memory_port_arbiter #(
  parameter int STARVE_LIMIT = 4
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataLoadRequest,
  input  logic        dataStoreRequest,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataStoreData,
  input  logic [3:0]  dataByteEnable,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  input  logic        fetchFlush,
  output logic [31:0] fetchData,
  output logic        fetchDataValid,
  output logic        memRequest,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  input  logic        memGrant,
  input  logic        memResponseValid,
  input  logic [31:0] memReadData
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  ,
  output logic        busTimeout
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LOAD, OWN_STORE, OWN_FETCH} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state, state_n;
  owner_t      owner, owner_n;
  logic [3:0]  starve, starve_n;
  logic        drop, drop_n;
  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n;
  logic [3:0]  be_n;

  logic        data_req;
  logic        fetch_elig;
  logic        fetch_wins;
  logic        done;
  logic [31:0] resp_data;

  assign data_req   = dataLoadRequest | dataStoreRequest;
  assign fetch_elig = fetchRequest & ~fetchFlush;
  assign fetch_wins = fetch_elig & (~data_req | (starve == STARVE_MAX));

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  // Down-counter loaded on entry to WAIT; terminal count 0 marks the last
  // permitted WAIT cycle.
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt, tmo_cnt_n;
  logic        tmo_hit;

  assign tmo_hit    = (state == WAIT) & ~memResponseValid & (tmo_cnt == 16'd0);
  assign busTimeout = tmo_hit;
  assign done       = (state == WAIT) & (memResponseValid | tmo_hit);
  assign resp_data  = memResponseValid ? memReadData : 32'h0000_0000;
`else
  assign done      = (state == WAIT) & memResponseValid;
  assign resp_data = memReadData;
`endif

  // Next-state, arbitration and combinational completion pulses.
  always_comb begin
    state_n        = state;
    owner_n        = owner;
    starve_n       = starve;
    drop_n         = drop;
    req_n          = memRequest;
    we_n           = memWriteEnable;
    addr_n         = memAddress;
    wdata_n        = memWriteData;
    be_n           = memByteEnable;
    loadData       = 32'h0000_0000;
    loadDataValid  = 1'b0;
    storeComplete  = 1'b0;
    fetchData      = 32'h0000_0000;
    fetchDataValid = 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    tmo_cnt_n      = tmo_cnt;
`endif

    case (state)
      IDLE: begin
        if (data_req || fetch_elig) begin
          state_n = ISSUE;
          req_n   = 1'b1;
          drop_n  = 1'b0;
          if (fetch_wins) begin
            owner_n  = OWN_FETCH;
            we_n     = 1'b0;
            addr_n   = {fetchAddress[31:2], 2'b00};
            wdata_n  = 32'h0000_0000;
            be_n     = 4'b1111;
            starve_n = 4'd0;
          end else begin
            // Store beats load when the Memory stage raises both.
            if (dataStoreRequest) begin
              owner_n = OWN_STORE;
              we_n    = 1'b1;
              wdata_n = dataStoreData;
              be_n    = dataByteEnable;
            end else begin
              owner_n = OWN_LOAD;
              we_n    = 1'b0;
              wdata_n = 32'h0000_0000;
              be_n    = 4'b1111;
            end
            addr_n = {dataAddress[31:2], 2'b00};
            if (!fetch_elig) begin
              starve_n = 4'd0;
            end else if (starve != STARVE_MAX) begin
              starve_n = starve + 4'd1;
            end
          end
        end else begin
          starve_n = 4'd0;
        end
      end

      ISSUE: begin
        if (owner == OWN_FETCH && fetchFlush) drop_n = 1'b1;
        if (memGrant) begin
          req_n   = 1'b0;
          state_n = WAIT;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          tmo_cnt_n = TMO_LOAD;
`endif
        end
      end

      WAIT: begin
        // A flushed fetch still completes on the bus; its data is discarded.
        if (owner == OWN_FETCH && fetchFlush) drop_n = 1'b1;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        if (tmo_cnt != 16'd0) tmo_cnt_n = tmo_cnt - 16'd1;
`endif
        if (done) begin
          state_n = IDLE;
          case (owner)
            OWN_LOAD: begin
              loadData      = resp_data;
              loadDataValid = dataLoadRequest;
            end
            OWN_STORE: storeComplete = 1'b1;
            OWN_FETCH: begin
              fetchData      = resp_data;
              fetchDataValid = ~drop & ~fetchFlush;
            end
            default: ;
          endcase
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and registered bus fields; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= OWN_NONE;
      starve         <= 4'd0;
      drop           <= 1'b0;
      memRequest     <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= 32'h0000_0000;
      memWriteData   <= 32'h0000_0000;
      memByteEnable  <= 4'b0000;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      tmo_cnt        <= 16'd0;
`endif
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      starve         <= starve_n;
      drop           <= drop_n;
      memRequest     <= req_n;
      memWriteEnable <= we_n;
      memAddress     <= addr_n;
      memWriteData   <= wdata_n;
      memByteEnable  <= be_n;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      tmo_cnt        <= tmo_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Testbench for memory_port_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level arbitration model.
module tb_memory_port_arbiter;

  localparam int LIMIT   = 4;
  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_FETCH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        dataLoadRequest, dataStoreRequest;
  logic [31:0] dataAddress, dataStoreData;
  logic [3:0]  dataByteEnable;
  logic [31:0] loadData;
  logic        loadDataValid, storeComplete;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchFlush;
  logic [31:0] fetchData;
  logic        fetchDataValid;
  logic        memRequest, memWriteEnable;
  logic [31:0] memAddress, memWriteData;
  logic [3:0]  memByteEnable;
  logic        memGrant, memResponseValid;
  logic [31:0] memReadData;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic        busTimeout;
`endif

  int checks = 0;
  int errors = 0;
  int m_starve = 0;

  memory_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .dataLoadRequest(dataLoadRequest), .dataStoreRequest(dataStoreRequest),
    .dataAddress(dataAddress), .dataStoreData(dataStoreData),
    .dataByteEnable(dataByteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid),
    .storeComplete(storeComplete),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress),
    .fetchFlush(fetchFlush),
    .fetchData(fetchData), .fetchDataValid(fetchDataValid),
    .memRequest(memRequest), .memWriteEnable(memWriteEnable),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memByteEnable(memByteEnable),
    .memGrant(memGrant), .memResponseValid(memResponseValid),
    .memReadData(memReadData)
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    , .busTimeout(busTimeout)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request levels applied in IDLE, grant after gd
  // extra ISSUE cycles, response after rd extra WAIT cycles.
  task automatic run_txn(input bit ld, input bit st, input bit fe,
                         input logic [31:0] daddr, input logic [31:0] sdata,
                         input logic [3:0] dbe, input logic [31:0] faddr,
                         input int gd, input int rd, input logic [31:0] rdat,
                         input bit flush_wait, input bit drop_load);
    int          kind;
    bit          dreq;
    bit          exp_lv, exp_fv;
    logic        ewe;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    dataLoadRequest  = ld;
    dataStoreRequest = st;
    fetchRequest     = fe;
    dataAddress      = daddr;
    dataStoreData    = sdata;
    dataByteEnable   = dbe;
    fetchAddress     = faddr;
    fetchFlush       = 1'b0;
    memGrant         = 1'b0;
    memResponseValid = 1'b0;
    dreq = ld | st;
    if (!dreq && !fe) begin
      m_starve = 0;
      tick(); #1;
      chk("noreq_memRequest", 32'(memRequest), 32'd0);
      return;
    end
    if (fe && (!dreq || m_starve == LIMIT)) begin
      kind = K_FETCH; m_starve = 0;
      ewe = 1'b0; ea = {faddr[31:2], 2'b00}; ew = 32'd0; eb = 4'b1111;
    end else begin
      m_starve = fe ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
      ea = {daddr[31:2], 2'b00};
      if (st) begin
        kind = K_STORE; ewe = 1'b1; ew = sdata; eb = dbe;
      end else begin
        kind = K_LOAD; ewe = 1'b0; ew = 32'd0; eb = 4'b1111;
      end
    end

    tick(); #1;
    chk("iss_req",  32'(memRequest), 32'd1);
    chk("iss_we",   32'(memWriteEnable), 32'(ewe));
    chk("iss_addr", memAddress, ea);
    chk("iss_be",   32'(memByteEnable), 32'(eb));
    if (ewe) chk("iss_wdata", memWriteData, ew);
    for (int i = 0; i < gd; i++) begin
      tick(); #1;
      chk("hold_req",  32'(memRequest), 32'd1);
      chk("hold_addr", memAddress, ea);
      chk("hold_be",   32'(memByteEnable), 32'(eb));
      if (ewe) chk("hold_wdata", memWriteData, ew);
    end
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    #1;
    chk("wait_req_low", 32'(memRequest), 32'd0);

    if (flush_wait) begin
      fetchFlush = 1'b1;
      tick();
      fetchFlush = 1'b0;
    end
    if (drop_load) dataLoadRequest = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      chk("wait_no_pulse", 32'({loadDataValid, storeComplete, fetchDataValid}), 32'd0);
      tick();
    end

    memResponseValid = 1'b1;
    memReadData      = rdat;
    #1;
    exp_lv = (kind == K_LOAD) && !drop_load;
    exp_fv = (kind == K_FETCH) && !flush_wait;
    chk("rsp_load_valid",  32'(loadDataValid),  32'(exp_lv));
    if (exp_lv) chk("rsp_load_data", loadData, rdat);
    chk("rsp_store_done",  32'(storeComplete),  32'(kind == K_STORE));
    chk("rsp_fetch_valid", 32'(fetchDataValid), 32'(exp_fv));
    if (exp_fv) chk("rsp_fetch_data", fetchData, rdat);

    tick();
    memResponseValid = 1'b0;
    #1;
    chk("post_no_pulse", 32'({loadDataValid, storeComplete, fetchDataValid}), 32'd0);
    chk("post_req_low",  32'(memRequest), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    dataLoadRequest = 0; dataStoreRequest = 0; dataAddress = 0;
    dataStoreData = 0; dataByteEnable = 0; fetchRequest = 0;
    fetchAddress = 0; fetchFlush = 0; memGrant = 0;
    memResponseValid = 0; memReadData = 0;
    repeat (2) tick();
    #1;
    chk("rst_memRequest",     32'(memRequest), 32'd0);
    chk("rst_memWriteEnable", 32'(memWriteEnable), 32'd0);
    chk("rst_memAddress",     memAddress, 32'd0);
    chk("rst_memWriteData",   memWriteData, 32'd0);
    chk("rst_memByteEnable",  32'(memByteEnable), 32'd0);
    chk("rst_pulses", 32'({loadDataValid, storeComplete, fetchDataValid}), 32'd0);
    chk("rst_loadData",  loadData, 32'd0);
    chk("rst_fetchData", fetchData, 32'd0);
    reset = 1'b1;
    tick();

    // Plain load with immediate grant and response.
    run_txn(1, 0, 0, 32'h104, 32'h0, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);

    // Load and fetch held together: four data wins, then fetch.
    for (int i = 0; i < 5; i++)
      run_txn(1, 0, 1, 32'h400 + 32'(i * 4), 32'h0, 4'h0, 32'h800,
              0, 0, 32'h1000 + 32'(i), 0, 0);

    // Store to an unaligned address with a delayed grant.
    run_txn(0, 1, 0, 32'h203, 32'hAB00_0000, 4'b1000, 32'h0, 3, 1, 32'h0, 0, 0);

    // Fetch flushed while waiting, then a normal fetch.
    run_txn(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h1000, 0, 1, 32'h0000_0013, 1, 0);
    run_txn(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h1004, 0, 0, 32'h0000_0013, 0, 0);

    // Store with no byte lanes, and a load abandoned by a pipeline flush.
    run_txn(0, 1, 0, 32'h30, 32'h1234_5678, 4'b0000, 32'h0, 1, 0, 32'h0, 0, 0);
    run_txn(1, 0, 0, 32'h44, 32'h0, 4'h0, 32'h0, 0, 2, 32'h5555_AAAA, 0, 1);
    // Load and store together: store wins.
    run_txn(1, 1, 0, 32'h58, 32'hCAFE_0001, 4'b0011, 32'h0, 0, 0, 32'h0, 0, 0);

    // Random transactions.
    for (int n = 0; n < 60; n++) begin
      bit ld, st, fe, fw, dl;
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      fe = 1'($urandom_range(0, 1));
      fw = ($urandom_range(0, 7) == 0);
      dl = ld && ($urandom_range(0, 7) == 0);
      run_txn(ld, st, fe, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, fw, dl);
    end

    // Reset during WAIT, then a stray response in IDLE.
    dataLoadRequest = 1; dataStoreRequest = 0; fetchRequest = 0;
    dataAddress = 32'h300;
    tick(); #1;
    chk("rst_pre_req", 32'(memRequest), 32'd1);
    memGrant = 1'b1;
    tick();
    memGrant = 1'b0;
    dataLoadRequest = 1'b0;
    reset = 1'b0;
    tick(); #1;
    chk("midrst_memRequest",     32'(memRequest), 32'd0);
    chk("midrst_memWriteEnable", 32'(memWriteEnable), 32'd0);
    chk("midrst_memAddress",     memAddress, 32'd0);
    chk("midrst_memWriteData",   memWriteData, 32'd0);
    chk("midrst_memByteEnable",  32'(memByteEnable), 32'd0);
    reset = 1'b1;
    memResponseValid = 1'b1;
    memReadData = 32'hCAFE_F00D;
    #1;
    chk("stray_pulses", 32'({loadDataValid, storeComplete, fetchDataValid}), 32'd0);
    chk("stray_loadData",  loadData, 32'd0);
    chk("stray_fetchData", fetchData, 32'd0);
    tick();
    memResponseValid = 1'b0;
    #1;
    chk("stray_req_low", 32'(memRequest), 32'd0);
    m_starve = 0;

    // Normal operation after reset.
    run_txn(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h2000, 0, 0, 32'h0BAD_F00D, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
